// File: rtl/lcd_st_fifo_param.sv
// Avalon-ST FIFO with SOP/EOP sideband, fill thresholds, synchronous flush and
// optional store-and-forward release with oversize-packet bypass.
module lcd_st_fifo_param #(
    parameter int DATA_WIDTH      = 69,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int PACKET_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  oversize
);

    localparam int                  WORD_W     = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_AF      = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] LP_AE      = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH:0] LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic                LP_PKT     = (PACKET_MODE != 0);

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic [ADDR_WIDTH:0]   r_pkt;
    logic                  r_head_vld;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_sop;
    logic                  r_head_eop;
    logic                  r_bypass;
    logic                  r_oversize;
    logic                  r_run;

    logic                  w_acc;
    logic                  w_con;
    logic                  w_release;
    logic                  w_deadlock;
    logic [ADDR_WIDTH:0]   w_unf;
    logic                  w_load_mem;
    logic                  w_load_in;
    logic                  w_load;
    logic [WORD_W-1:0]     w_in_word;
    logic [WORD_W-1:0]     w_head_next;

    assign in_ready  = r_run && (r_fill != LP_DEPTH) && !clear;
    assign w_release = !LP_PKT || (r_pkt != '0) || r_bypass;
    assign out_valid = r_head_vld && w_release;

    assign w_acc = in_valid && in_ready;
    assign w_con = out_valid && out_ready && !clear;

    // Words in memory not yet copied into the head register.
    assign w_unf = r_fill - {{ADDR_WIDTH{1'b0}}, r_head_vld};

    // Refill from memory when the head is empty or leaving; if memory is
    // drained while a beat is consumed, take the incoming beat straight into
    // the head so a steady 1-in/1-out stream at fill 1 has no bubble.
    assign w_load_mem  = (w_unf != '0) && (!r_head_vld || w_con);
    assign w_load_in   = (w_unf == '0) && r_head_vld && w_con && w_acc;
    assign w_load      = w_load_mem || w_load_in;
    assign w_in_word   = {in_startofpacket, in_endofpacket, in_data};
    assign w_head_next = w_load_in ? w_in_word : r_mem[r_rd_ptr];

    // Full with no complete packet can never release in store-and-forward.
    assign w_deadlock = LP_PKT && (r_fill == LP_DEPTH) && (r_pkt == '0);

    always_ff @(posedge clk) begin
        if (w_acc)
            r_mem[r_wr_ptr] <= w_in_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_pkt       <= '0;
            r_head_vld  <= 1'b0;
            r_head_data <= '0;
            r_head_sop  <= 1'b0;
            r_head_eop  <= 1'b0;
            r_bypass    <= 1'b0;
            r_oversize  <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fill     <= '0;
                r_pkt      <= '0;
                r_head_vld <= 1'b0;
                r_bypass   <= 1'b0;
                r_oversize <= 1'b0;
            end else begin
                if (w_acc)
                    r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;

                if (w_load) begin
                    r_rd_ptr   <= r_rd_ptr + LP_PTR_ONE;
                    r_head_vld <= 1'b1;
                    {r_head_sop, r_head_eop, r_head_data} <= w_head_next;
                end else if (w_con) begin
                    r_head_vld <= 1'b0;
                end

                case ({w_acc, w_con})
                    2'b10:   r_fill <= r_fill + LP_CNT_ONE;
                    2'b01:   r_fill <= r_fill - LP_CNT_ONE;
                    default: r_fill <= r_fill;
                endcase

                case ({w_acc && in_endofpacket, w_con && r_head_eop})
                    2'b10:   r_pkt <= r_pkt + LP_CNT_ONE;
                    2'b01:   r_pkt <= r_pkt - LP_CNT_ONE;
                    default: r_pkt <= r_pkt;
                endcase

                if (w_con && r_head_eop)
                    r_bypass <= 1'b0;
                else if (w_deadlock)
                    r_bypass <= 1'b1;

                if (w_deadlock)
                    r_oversize <= 1'b1;
            end
        end
    end

    assign out_data          = r_head_data;
    assign out_startofpacket = r_head_sop;
    assign out_endofpacket   = r_head_eop;
    assign fill_level        = r_fill;
    assign pkt_count         = r_pkt;
    assign almost_full       = (r_fill >= LP_AF);
    assign almost_empty      = (r_fill <= LP_AE);
    assign oversize          = r_oversize;

endmodule

// File: tb/tb_lcd_st_fifo_param.sv
// Scoreboard bench: lane 0 is a cut-through FIFO, lane 1 store-and-forward;
// a per-lane monitor compares every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_lcd_st_fifo_param;

    localparam int DW    = 69;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct packed {
        logic          s;
        logic          e;
        logic [DW-1:0] d;
    } beat_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    logic [1:0]         clear_a     = '0;
    logic [1:0]         in_valid_a  = '0;
    logic [1:0]         in_sop_a    = '0;
    logic [1:0]         in_eop_a    = '0;
    logic [1:0]         out_ready_a = '0;
    logic [1:0][DW-1:0] in_data_a   = '0;

    wire [1:0]         in_ready_w, out_valid_w, out_sop_w, out_eop_w, af_w, ae_w, ov_w;
    wire [1:0][DW-1:0] out_data_w;
    wire [1:0][AW:0]   fill_w, pkt_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0h, expected %0h", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam bit PM = (g == 1);

        lcd_st_fifo_param #(
            .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
            .ALMOST_FULL_TH(DEPTH - 2), .ALMOST_EMPTY_TH(2), .PACKET_MODE(g)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .clear(clear_a[g]),
            .in_ready(in_ready_w[g]), .in_valid(in_valid_a[g]), .in_data(in_data_a[g]),
            .in_startofpacket(in_sop_a[g]), .in_endofpacket(in_eop_a[g]),
            .out_ready(out_ready_a[g]), .out_valid(out_valid_w[g]), .out_data(out_data_w[g]),
            .out_startofpacket(out_sop_w[g]), .out_endofpacket(out_eop_w[g]),
            .fill_level(fill_w[g]), .almost_full(af_w[g]), .almost_empty(ae_w[g]),
            .pkt_count(pkt_w[g]), .oversize(ov_w[g])
        );

        beat_t q[$];
        int    last_sz = 0;
        bit    bp = 0, ov = 0, run = 0;

        always @(negedge clk) begin : mon
            int    sz, eopc;
            logic  exp_rdy, exp_vld, acc, con, cond, pop_eop;
            beat_t h;
            if (!reset_n) begin
                q.delete();
                last_sz = 0; bp = 0; ov = 0; run = 0;
            end else begin
                sz   = q.size();
                eopc = 0;
                foreach (q[i]) if (q[i].e) eopc++;
                exp_rdy = run && (sz != DEPTH) && !clear_a[g];
                // A beat landing in an empty FIFO needs one edge to reach the head.
                exp_vld = (sz > 0) && (last_sz > 0) && (!PM || eopc > 0 || bp);
                chk("fill_level", g, fill_w[g], sz);
                chk("pkt_count", g, pkt_w[g], eopc);
                chk("in_ready", g, in_ready_w[g], exp_rdy);
                chk("out_valid", g, out_valid_w[g], exp_vld);
                chk("almost_full", g, af_w[g], sz >= DEPTH - 2);
                chk("almost_empty", g, ae_w[g], sz <= 2);
                chk("oversize", g, ov_w[g], ov);

                acc     = in_valid_a[g] && in_ready_w[g];
                con     = out_valid_w[g] && out_ready_a[g] && !clear_a[g];
                pop_eop = 1'b0;
                if (con) begin
                    if (q.size() == 0) begin
                        chk("underflow", g, con, 1'b0);
                    end else begin
                        h = q.pop_front();
                        pop_eop = h.e;
                        chk("head_beat", g, {out_sop_w[g], out_eop_w[g], out_data_w[g]}, h);
                    end
                end

                cond = PM && (sz == DEPTH) && (eopc == 0);
                if (clear_a[g]) begin
                    q.delete();
                    bp = 0; ov = 0; last_sz = 0;
                end else begin
                    last_sz = sz;
                    if (con && pop_eop) bp = 0;
                    else if (cond)      bp = 1;
                    if (cond) ov = 1;
                    if (acc) q.push_back(beat_t'({in_sop_a[g], in_eop_a[g], in_data_a[g]}));
                end
                run = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int g);
        in_valid_a[g] = 1'b0;
        in_sop_a[g]   = 1'b0;
        in_eop_a[g]   = 1'b0;
        clear_a[g]    = 1'b0;
    endtask

    task automatic drive_beat(input int g, input logic [DW-1:0] d, input logic s, input logic e);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_valid_a[g] = 1'b1;
        in_data_a[g]  = d;
        in_sop_a[g]   = s;
        in_eop_a[g]   = e;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready_w[g];
            @(posedge clk);
            #1;
            n++;
        end
        idle(g);
        chk("accept_timeout", g, acc, 1'b1);
    endtask

    task automatic run_random(input int g, input int cycles, input int eop_pct);
        int   p_in, p_out, cnt;
        logic acc;
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            // Alternate producer-heavy and consumer-heavy phases to hit full and empty.
            p_in  = ((c / 150) % 2 == 0) ? 85 : 30;
            p_out = ((c / 150) % 2 == 0) ? 30 : 85;
            in_valid_a[g]  = ($urandom_range(0, 99) < p_in);
            in_data_a[g]   = {5'($urandom), 32'($urandom), 32'(cnt)};
            in_sop_a[g]    = ($urandom_range(0, 3) == 0);
            in_eop_a[g]    = ($urandom_range(0, 99) < eop_pct);
            out_ready_a[g] = ($urandom_range(0, 99) < p_out);
            @(negedge clk);
            acc = in_valid_a[g] && in_ready_w[g];
            @(posedge clk);
            #1;
            if (acc) cnt++;
        end
        idle(g);
    endtask

    task automatic check_reset();
        for (int g = 0; g < 2; g++) begin
            chk("rst_in_ready", g, in_ready_w[g], 1'b0);
            chk("rst_out_valid", g, out_valid_w[g], 1'b0);
            chk("rst_out_beat", g, {out_sop_w[g], out_eop_w[g], out_data_w[g]}, '0);
            chk("rst_fill", g, fill_w[g], '0);
            chk("rst_pkt", g, pkt_w[g], '0);
            chk("rst_almost_full", g, af_w[g], 1'b0);
            chk("rst_almost_empty", g, ae_w[g], 1'b1);
            chk("rst_oversize", g, ov_w[g], 1'b0);
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2 check_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) cyc();

        // Cut-through fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid_a[0] = 1'b1;
            in_data_a[0]  = DW'(i);
            in_sop_a[0]   = (i == 0);
            in_eop_a[0]   = (i == DEPTH - 1);
            cyc();
        end
        idle(0);
        cyc();
        out_ready_a[0] = 1'b1;
        repeat (DEPTH + 3) cyc();

        // Random streaming across many pointer wraps.
        run_random(0, 2000, 20);
        out_ready_a[0] = 1'b1;
        repeat (DEPTH + 3) cyc();

        // Store-and-forward: a 5-beat packet is held until its EOP arrives.
        out_ready_a[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid_a[1] = 1'b1;
            in_data_a[1]  = DW'(32'h500 + i);
            in_sop_a[1]   = (i == 0);
            in_eop_a[1]   = (i == 4);
            cyc();
        end
        idle(1);
        repeat (10) cyc();

        // Oversize packet forces the bypass; oversize then stays set.
        for (int i = 0; i < 12; i++)
            drive_beat(1, DW'(32'hC00 + i), i == 0, i == 11);
        repeat (15) cyc();

        // Random packet traffic, closed with a final EOP so everything drains.
        run_random(1, 600, 25);
        out_ready_a[1] = 1'b1;
        drive_beat(1, DW'(32'hEEE), 1'b0, 1'b1);
        repeat (DEPTH + 3) cyc();

        // Flush mid-stream; the beat offered during clear is dropped.
        out_ready_a[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_a[1] = 1'b1;
            in_data_a[1]  = DW'(32'hF00 + i);
            in_sop_a[1]   = (i == 0 || i == 3);
            in_eop_a[1]   = (i == 2);
            cyc();
        end
        clear_a[1]    = 1'b1;
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = DW'(32'hDEAD);
        cyc();
        idle(1);
        repeat (3) cyc();
        out_ready_a[1] = 1'b1;
        drive_beat(1, DW'(32'hF10), 1'b1, 1'b1);
        repeat (5) cyc();

        // Asynchronous reset between edges while partly full.
        out_ready_a = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 2'b11;
            in_data_a[0] = DW'(32'hA00 + i);
            in_data_a[1] = DW'(32'hB00 + i);
            in_eop_a   = (i == 1) ? 2'b11 : 2'b00;
            cyc();
        end
        idle(0);
        idle(1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready_a = 2'b11;
        repeat (3) cyc();
        drive_beat(0, DW'(32'h123), 1'b1, 1'b1);
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lcd_st_fifo_param.md
# lcd_st_fifo_param

Parametrised Avalon-ST FIFO for the LCD/DFA streaming path. It carries DATA_WIDTH-bit beats with start-of-packet and end-of-packet flags. It adds fill-level thresholds, a synchronous flush and an optional store-and-forward packet mode. It sits between streaming producers (LCD timing adapter, FFT output) and consumers that need either cut-through or whole-packet delivery.

## Interface
Parameters:
- DATA_WIDTH, 69: payload width in bits.
- DEPTH, 8: total capacity in words; power of two, ≥4.
- ADDR_WIDTH, 3: log2(DEPTH); must match DEPTH.
- ALMOST_FULL_TH, DEPTH-2: almost_full asserted when fill_level ≥ this value.
- ALMOST_EMPTY_TH, 2: almost_empty asserted when fill_level ≤ this value.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous flush, active-high.
- in_ready  out  1  sink can accept a beat.
- in_valid  in  1  source beat valid.
- in_data  in  DATA_WIDTH  payload.
- in_startofpacket  in  1  SOP flag.
- in_endofpacket  in  1  EOP flag.
- out_ready  in  1  downstream accepts.
- out_valid  out  1  head beat valid.
- out_data  out  DATA_WIDTH  head payload.
- out_startofpacket  out  1  head SOP.
- out_endofpacket  out  1  head EOP.
- fill_level  out  ADDR_WIDTH+1  stored words, 0..DEPTH.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- pkt_count  out  ADDR_WIDTH+1  complete packets stored (EOP count).
- oversize  out  1  sticky flag: packet larger than DEPTH seen in packet mode.

## Operation
- Storage is DEPTH words of DATA_WIDTH+2 bits: payload, SOP and EOP. Write pointer and read pointer are ADDR_WIDTH bits and wrap modulo DEPTH. A registered head stage feeds the out_* signals; the head stage counts toward fill_level.
- Accept: in_valid && in_ready at a rising edge. Consume: out_valid && out_ready at a rising edge.
- in_ready = (fill_level != DEPTH) && !clear. It is decoded from registers only and never depends on out_ready in the same cycle.
- fill_level: +1 on accept-only, −1 on consume-only, unchanged when both occur. It is exact at every edge and covers both the full and empty cases.
- almost_full and almost_empty are combinational compares on registered fill_level.
- pkt_count: +1 on accept of an EOP beat, −1 on consume of an EOP beat, unchanged when both occur.
- out_valid = head_loaded && release.
  - When PACKET_MODE=0, release is always 1.
  - When PACKET_MODE=1, release = (pkt_count != 0) || bypass.
- Deadlock avoidance in packet mode:
  - When fill_level == DEPTH and pkt_count == 0, set bypass and the sticky oversize flag.
  - bypass clears on consume of an EOP beat.
  - oversize clears only on clear or reset.
- clear:
  - At the edge where clear is high, set pointers, fill_level and pkt_count to 0, and set head_loaded, bypass and oversize to 0.
  - Any simultaneous in_valid or out_ready beat is discarded.
- Reset values: in_ready 0 while reset_n is low and 1 after release. The following outputs are 0: out_valid, out_data, out_startofpacket, out_endofpacket, fill_level, pkt_count, almost_full and oversize. almost_empty is 1.
- Reset asserted mid-packet discards all contents immediately. There is no partial-packet recovery.

## Timing
- Read latency, cut-through: a beat accepted at edge E into an empty FIFO drives out_valid high from edge E+1. The memory read is registered at E+1.
- Read latency, packet mode: out_valid rises at the later of two edges:
  - the edge after which head_loaded is set;
  - the edge at which an EOP beat is accepted, which makes pkt_count nonzero.
- Throughput: one accept and one consume per cycle, sustained, for any fill_level in 1..DEPTH−1.
- Head prefetch: on consume, the next word is read so that out_data is valid at the following edge with no bubble.
- Full: after the DEPTH-th outstanding accept, in_ready falls at that edge. in_ready rises at the first consume edge.
- Empty: after the last consume, out_valid falls at that edge.
- out_data, out_startofpacket and out_endofpacket are stable while out_valid && !out_ready.
- Ordering is strict FIFO across pointer wrap-around.

## Test plan
- Fill and drain, PACKET_MODE=0, DEPTH=8:
  - Stimulus: after reset, assert in_valid for 8 cycles with out_ready=0, then out_ready=1 with in_valid=0.
  - Response: in_ready=0 exactly after the 8th accept. fill_level runs 0..8. almost_full rises at fill 6. Data is drained in order 0..7. out_valid=0 after the 8th consume.
- Random streaming:
  - Stimulus: 2000 cycles of random in_valid and out_ready with an incrementing payload, crossing wrap-around many times.
  - Response: no data loss or reorder. fill_level always equals the scoreboard count.
- Store-and-forward, PACKET_MODE=1:
  - Stimulus: send a 5-beat packet (SOP on beat 0, EOP on beat 4) with out_ready=1.
  - Response: out_valid stays 0 until the EOP is accepted. pkt_count goes 0→1→0. All 5 beats arrive back-to-back with correct SOP/EOP.
- Oversize packet, PACKET_MODE=1, DEPTH=8:
  - Stimulus: send a 12-beat packet.
  - Response: at fill 8 with pkt_count 0, oversize=1 and bypass releases data. All 12 beats are delivered in order. oversize stays 1 until clear.
- Flush mid-stream:
  - Stimulus: load 5 words, then pulse clear for 1 cycle with in_valid=1.
  - Response: the next cycle shows fill_level=0, out_valid=0, pkt_count=0. The beat offered during clear is not stored.
- Async reset mid-operation:
  - Stimulus: drop reset_n between edges while half full.
  - Response: all outputs take their reset values immediately, without waiting for a clock edge.
